// File: rtl/lemon_pkg.sv
// Shared defaults and state encoding for the lemon instruction fetch unit.
package lemon_pkg;

    localparam int          DEFAULT_XLEN       = 64;
    localparam int          DEFAULT_INST_W     = 32;
    localparam logic [63:0] DEFAULT_RESET_PC   = 64'h0000_0000_8000_0000;
    localparam int          DEFAULT_INST_BYTES = 4;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2,
        HOLD  = 2'd3
    } ifu_state_t;

endpackage

// File: rtl/lemon_ifu_obuf.sv
// One-entry holding register for the {pc, inst, misalign} beat presented to decode.
module lemon_ifu_obuf #(
    parameter int XLEN   = 64,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [XLEN-1:0]   load_pc,
    input  logic [INST_W-1:0] load_inst,
    input  logic              load_misalign,
    output logic              valid,
    output logic [XLEN-1:0]   pc,
    output logic [INST_W-1:0] inst,
    output logic              misalign
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            pc       <= '0;
            inst     <= '0;
            misalign <= 1'b0;
        end else if (load) begin
            valid    <= 1'b1;
            pc       <= load_pc;
            inst     <= load_inst;
            misalign <= load_misalign;
        end else if (clear) begin
            valid    <= 1'b0;
            pc       <= '0;
            inst     <= '0;
            misalign <= 1'b0;
        end
    end

endmodule

// File: rtl/lemon_ifu.sv
// Multi-cycle instruction fetch unit: PC, one-outstanding imem request, redirect/flush handling.
// Optional misaligned-PC trap path enabled by defining IFU_MISALIGN_CHECK_EN.
module lemon_ifu
    import lemon_pkg::*;
#(
    parameter int              XLEN       = DEFAULT_XLEN,
    parameter int              INST_W     = DEFAULT_INST_W,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEFAULT_RESET_PC),
    parameter int              INST_BYTES = DEFAULT_INST_BYTES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic              out_misalign
);

`ifdef IFU_MISALIGN_CHECK_EN
    localparam bit MISALIGN_EN = 1'b1;
`else
    localparam bit MISALIGN_EN = 1'b0;
`endif

    ifu_state_t        state;
    logic [XLEN-1:0]   pc;
    logic              req_valid;
    logic [XLEN-1:0]   pc_inc;
    logic              obuf_load;
    logic              obuf_clear;
    logic              load_misalign;
    logic [INST_W-1:0] load_inst;

    // A PC that may be fetched; misaligned PCs divert to the trap beat instead of memory.
    function automatic logic fetch_ok(input logic [XLEN-1:0] addr);
        return !MISALIGN_EN || ((addr % XLEN'(INST_BYTES)) == '0);
    endfunction

    assign pc_inc         = pc + XLEN'(INST_BYTES);
    assign imem_req_valid = req_valid;
    assign imem_req_addr  = pc;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        obuf_load     = 1'b0;
        obuf_clear    = 1'b0;
        load_misalign = 1'b0;
        case (state)
            REQ:  if (MISALIGN_EN && !req_valid && !redirect_valid) begin
                      obuf_load     = 1'b1;
                      load_misalign = 1'b1;
                  end
            WAIT: if (imem_resp_valid && !redirect_valid) obuf_load = 1'b1;
            HOLD: if (redirect_valid || (out_ready && !out_misalign)) obuf_clear = 1'b1;
            default: ;
        endcase
        load_inst = load_misalign ? '0 : imem_resp_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= REQ;
            pc        <= RESET_PC;
            req_valid <= fetch_ok(RESET_PC);
        end else begin
            case (state)
                REQ: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                        if (req_valid && imem_req_ready) begin
                            state     <= FLUSH;
                            req_valid <= 1'b0;
                        end else begin
                            req_valid <= fetch_ok(redirect_pc);
                        end
                    end else if (!req_valid) begin
                        state <= HOLD;
                    end else if (imem_req_ready) begin
                        state     <= WAIT;
                        req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                        if (imem_resp_valid) begin
                            state     <= REQ;
                            req_valid <= fetch_ok(redirect_pc);
                        end else begin
                            state <= FLUSH;
                        end
                    end else if (imem_resp_valid) begin
                        state <= HOLD;
                    end
                end
                FLUSH: begin
                    // Stale response still owed by memory; swallow it before re-requesting.
                    if (redirect_valid) pc <= redirect_pc;
                    if (imem_resp_valid) begin
                        state     <= REQ;
                        req_valid <= fetch_ok(redirect_valid ? redirect_pc : pc);
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        pc        <= redirect_pc;
                        state     <= REQ;
                        req_valid <= fetch_ok(redirect_pc);
                    end else if (out_ready && !out_misalign) begin
                        pc        <= pc_inc;
                        state     <= REQ;
                        req_valid <= fetch_ok(pc_inc);
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

    lemon_ifu_obuf #(
        .XLEN   (XLEN),
        .INST_W (INST_W)
    ) u_obuf (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (obuf_load),
        .clear         (obuf_clear),
        .load_pc       (pc),
        .load_inst     (load_inst),
        .load_misalign (load_misalign),
        .valid         (out_valid),
        .pc            (out_pc),
        .inst          (out_inst),
        .misalign      (out_misalign)
    );

endmodule

// File: tb/tb_lemon_ifu.sv
// Scoreboard bench for lemon_ifu: directed redirect/stall/wrap scenarios against a variable-latency memory.
module tb_lemon_ifu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        out_misalign;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } beat_t;

    logic [63:0] exp_req[$];
    beat_t       exp_out[$];
    int          total  = 0;
    int          passed = 0;
    int          mem_lat = 1;
    int          pend_cnt = 0;
    logic [63:0] pend_addr = '0;

    lemon_ifu dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_inst        (out_inst),
        .out_misalign    (out_misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_event(input string name, input logic [63:0] act);
        total++;
        $display("FAIL %s: got %h expected nothing", name, act);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_data(input logic [63:0] a);
        case (a)
            64'h8000_0000: return 32'h0010_0093;
            64'h8000_0004: return 32'h0020_0113;
            64'h8000_0008: return 32'h0030_0193;
            64'h8000_0100: return 32'h0040_0213;
            64'h8000_0200: return 32'h0060_0313;
            64'h8000_0300: return 32'h0070_0393;
            default:       return 32'h0000_0013;
        endcase
    endfunction

    // Memory model: one response mem_lat cycles after each accepted request.
    initial begin
        logic        acc_now;
        logic [63:0] acc_addr;
        forever begin
            @(negedge clk);
            acc_now  = rst_n && imem_req_valid && imem_req_ready;
            acc_addr = imem_req_addr;
            @(posedge clk);
            #1;
            imem_resp_valid = 1'b0;
            if (acc_now) begin
                pend_cnt  = mem_lat;
                pend_addr = acc_addr;
            end
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mem_data(pend_addr);
                end
            end
        end
    end

    // Request monitor.
    initial forever begin
        @(negedge clk);
        if (rst_n && imem_req_valid && imem_req_ready) begin
            if (exp_req.size() == 0) fail_event("req_unexpected", imem_req_addr);
            else check("req_addr", imem_req_addr, exp_req.pop_front());
        end
    end

    // Decode-side monitor: a beat counts only on a handshake not voided by redirect.
    initial forever begin
        @(negedge clk);
        if (rst_n && out_valid && out_ready && !redirect_valid && !out_misalign) begin
            if (exp_out.size() == 0) fail_event("out_unexpected", out_pc);
            else begin
                beat_t b;
                b = exp_out.pop_front();
                check("out_pc", out_pc, b.pc);
                check("out_inst", 64'(out_inst), 64'(b.inst));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cycles;
        int first_seen;
        int second_seen;

        // Reset state
        repeat (3) step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_pc", out_pc, 64'd0);
        check("rst_out_inst", 64'(out_inst), 64'd0);
        check("rst_out_misalign", 64'(out_misalign), 64'd0);
        check("rst_req_valid", 64'(imem_req_valid), 64'd1);
        check("rst_req_addr", imem_req_addr, 64'h8000_0000);

        // First fetch: REQ, WAIT, then HOLD visible after two edges
        exp_req.push_back(64'h8000_0000);
        rst_n = 1'b1;
        cycles = 0;
        while (!out_valid && cycles < 20) begin step(); cycles++; end
        check("first_latency", 64'(cycles), 64'd2);
        check("first_pc", out_pc, 64'h8000_0000);
        check("first_inst", 64'(out_inst), 64'h0010_0093);

        // Decode stall: beat held stable, no new request
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_pc", out_pc, 64'h8000_0000);
            check("stall_inst", 64'(out_inst), 64'h0010_0093);
            check("stall_no_req", 64'(imem_req_valid), 64'd0);
        end
        imem_req_ready = 1'b0;
        exp_out.push_back('{64'h8000_0000, 32'h0010_0093});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("seq_req_valid", 64'(imem_req_valid), 64'd1);
        check("seq_req_addr", imem_req_addr, 64'h8000_0004);
        check("seq_out_idle", 64'(out_valid), 64'd0);

        // Throughput: one instruction per three cycles
        exp_req.push_back(64'h8000_0004);
        exp_req.push_back(64'h8000_0008);
        exp_out.push_back('{64'h8000_0004, 32'h0020_0113});
        exp_out.push_back('{64'h8000_0008, 32'h0030_0193});
        imem_req_ready = 1'b1;
        out_ready = 1'b1;
        first_seen = -1;
        second_seen = -1;
        for (int c = 1; c <= 5; c++) begin
            step();
            if (out_valid) begin
                if (first_seen < 0) first_seen = c;
                else second_seen = c;
            end
            if (c == 5) imem_req_ready = 1'b0;
        end
        step();
        out_ready = 1'b0;
        check("tp_first", 64'(first_seen), 64'd2);
        check("tp_spacing", 64'(second_seen - first_seen), 64'd3);
        check("tp_next_addr", imem_req_addr, 64'h8000_000C);

        // Redirect during WAIT; late response must be swallowed in FLUSH
        exp_req.push_back(64'h8000_000C);
        exp_req.push_back(64'h8000_0100);
        mem_lat = 3;
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0100;
        step();
        redirect_valid = 1'b0;
        check("flush_no_req", 64'(imem_req_valid), 64'd0);
        step();
        step();
        check("flush_req_valid", 64'(imem_req_valid), 64'd1);
        check("flush_req_addr", imem_req_addr, 64'h8000_0100);
        check("flush_out_idle", 64'(out_valid), 64'd0);
        mem_lat = 1;
        imem_req_ready = 1'b1;
        cycles = 0;
        while (!out_valid && cycles < 20) begin step(); cycles++; end
        check("redir_out_valid", 64'(out_valid), 64'd1);
        check("redir_out_pc", out_pc, 64'h8000_0100);
        check("redir_out_inst", 64'(out_inst), 64'h0040_0213);

        // Redirect in HOLD beats out_ready: no pc+4 request
        imem_req_ready = 1'b0;
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0200;
        step();
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        check("hold_redir_req", 64'(imem_req_valid), 64'd1);
        check("hold_redir_addr", imem_req_addr, 64'h8000_0200);
        check("hold_redir_idle", 64'(out_valid), 64'd0);

        // Redirect coincident with response in WAIT: data dropped
        exp_req.push_back(64'h8000_0200);
        mem_lat = 2;
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        step();
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0300;
        step();
        redirect_valid = 1'b0;
        check("coinc_req_addr", imem_req_addr, 64'h8000_0300);
        check("coinc_req_valid", 64'(imem_req_valid), 64'd1);
        check("coinc_out_idle", 64'(out_valid), 64'd0);
        check("coinc_inst_dropped", 64'(out_inst == 32'h0060_0313), 64'd0);
        step();
        check("coinc_still_idle", 64'(out_valid), 64'd0);
        exp_req.push_back(64'h8000_0300);
        exp_out.push_back('{64'h8000_0300, 32'h0070_0393});
        mem_lat = 1;
        imem_req_ready = 1'b1;
        out_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        step();
        step();
        out_ready = 1'b0;
        check("target_next_addr", imem_req_addr, 64'h8000_0304);
        check("target_beat_taken", 64'(exp_out.size()), 64'd0);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        check("wrap_req_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        exp_req.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        exp_out.push_back('{64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0013});
        imem_req_ready = 1'b1;
        out_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        step();
        step();
        out_ready = 1'b0;
        check("wrap_next_addr", imem_req_addr, 64'd0);
        check("wrap_next_valid", 64'(imem_req_valid), 64'd1);

        // Redirect in the same cycle a request is accepted
        exp_req.push_back(64'd0);
        mem_lat = 2;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0400;
        step();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        check("acc_redir_no_req", 64'(imem_req_valid), 64'd0);
        step();
        step();
        check("acc_redir_req_valid", 64'(imem_req_valid), 64'd1);
        check("acc_redir_addr", imem_req_addr, 64'h8000_0400);
        check("acc_redir_idle", 64'(out_valid), 64'd0);
        mem_lat = 1;

`ifdef IFU_MISALIGN_CHECK_EN
        // Misaligned target: no memory request, trap beat held until redirect
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0002;
        step();
        redirect_valid = 1'b0;
        check("mis_no_req", 64'(imem_req_valid), 64'd0);
        step();
        check("mis_valid", 64'(out_valid), 64'd1);
        check("mis_flag", 64'(out_misalign), 64'd1);
        check("mis_pc", out_pc, 64'h8000_0002);
        check("mis_inst", 64'(out_inst), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("mis_hold_valid", 64'(out_valid), 64'd1);
            check("mis_hold_no_req", 64'(imem_req_valid), 64'd0);
        end
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0200;
        step();
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        check("mis_exit_req", 64'(imem_req_valid), 64'd1);
        check("mis_exit_addr", imem_req_addr, 64'h8000_0200);
        check("mis_exit_idle", 64'(out_valid), 64'd0);
`else
        // Without the check, a misaligned target is fetched as-is
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0002;
        step();
        redirect_valid = 1'b0;
        check("unal_req_valid", 64'(imem_req_valid), 64'd1);
        check("unal_req_addr", imem_req_addr, 64'h8000_0002);
        check("unal_no_flag", 64'(out_misalign), 64'd0);
`endif

        repeat (3) step();
        check("req_queue_drained", 64'(exp_req.size()), 64'd0);
        check("out_queue_drained", 64'(exp_out.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
